// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin hold arbiter: index width helper and FSM encoding.
`default_nettype none

package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: lowest set request at or above i_start, else lowest overall.
`default_nettype none

module rr_priority_pick
  import rr_arb_pkg::*;
#(
  parameter  int N   = 32,
  localparam int IDW = calc_idw(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_start,
  output logic [N-1:0]   o_pick,
  output logic [IDW-1:0] o_idx,
  output logic           o_found
);

  logic [N-1:0]   w_mask;
  logic [N-1:0]   w_masked;
  logic [N-1:0]   w_src;
  logic [N-1:0]   w_pick;
  logic [IDW-1:0] w_idx;

  // Isolating the lowest set bit with x & -x keeps the carry chain as the only long path.
  always_comb begin
    w_mask   = {N{1'b1}} << i_start;
    w_masked = i_req & w_mask;
    w_src    = (|w_masked) ? w_masked : i_req;
    w_pick   = w_src & (~w_src + N'(1));
    w_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i]) w_idx = w_idx | IDW'(i);
    end
  end

  assign o_pick  = w_pick;
  assign o_idx   = w_idx;
  assign o_found = |i_req;

endmodule

`default_nettype wire

// File: rtl/rr_hold_arbiter.sv
// N-way arbiter (round-robin or fixed priority) that holds a registered one-hot grant until release.
`default_nettype none

module rr_hold_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N          = 32,
  parameter  int FIXED_PRIO = 0,
  localparam int IDW        = calc_idw(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_i,
  input  logic           release_i,
  output logic [N-1:0]   gnt_o,
  output logic           gnt_valid_o,
  output logic [IDW-1:0] gnt_id_o
);

  state_t         r_state;
  logic [N-1:0]   r_gnt;
  logic           r_valid;
  logic [IDW-1:0] r_gnt_id;
  logic [IDW-1:0] r_ptr;

  logic           w_release;
  logic [IDW-1:0] w_ptr_adv;
  logic [IDW-1:0] w_start;
  logic [N-1:0]   w_pick;
  logic [IDW-1:0] w_pick_idx;
  logic           w_found;

  // Dropping the request is treated the same as an explicit release.
  assign w_release = release_i | ~(|(req_i & r_gnt));

  generate
    if (FIXED_PRIO != 0 || N == 1) begin : g_ptr_zero
      assign w_ptr_adv = '0;
    end else begin : g_ptr_rr
      assign w_ptr_adv = (r_gnt_id == IDW'(N - 1)) ? '0 : r_gnt_id + IDW'(1);
    end
  endgenerate

  // On a release the pick must already see the advanced pointer to avoid a bubble.
  assign w_start = (r_state == ST_BUSY) ? w_ptr_adv : r_ptr;

  rr_priority_pick #(
    .N (N)
  ) u_pick (
    .i_req   (req_i),
    .i_start (w_start),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_valid  <= 1'b0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt    <= w_pick;
            r_gnt_id <= w_pick_idx;
            r_valid  <= 1'b1;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_ptr <= w_ptr_adv;
            if (w_found) begin
              r_gnt    <= w_pick;
              r_gnt_id <= w_pick_idx;
            end else begin
              r_gnt    <= '0;
              r_gnt_id <= '0;
              r_valid  <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_valid_o = r_valid;
  assign gnt_id_o    = r_gnt_id;

endmodule

`default_nettype wire

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench: round-robin N=4, fixed-priority N=4 and N=1 arbiters against a queue-free reference model.
`default_nettype none

module tb_rr_hold_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_rr, req_fx;
  logic [0:0] req_1;
  logic       rel_rr, rel_fx, rel_1;

  logic [3:0] g_rr, g_fx;
  logic [0:0] g_1;
  logic       v_rr, v_fx, v_1;
  logic [1:0] id_rr, id_fx;
  logic [0:0] id_1;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: owner index (-1 = none) and round-robin pointer per instance.
  int m_own[3];
  int m_ptr[3];
  int m_n[3]   = '{4, 4, 1};
  bit m_fix[3] = '{1'b0, 1'b1, 1'b0};

  rr_hold_arbiter #(.N(4), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset), .req_i(req_rr), .release_i(rel_rr),
    .gnt_o(g_rr), .gnt_valid_o(v_rr), .gnt_id_o(id_rr)
  );

  rr_hold_arbiter #(.N(4), .FIXED_PRIO(1)) dut_fx (
    .clk(clk), .reset(reset), .req_i(req_fx), .release_i(rel_fx),
    .gnt_o(g_fx), .gnt_valid_o(v_fx), .gnt_id_o(id_fx)
  );

  rr_hold_arbiter #(.N(1), .FIXED_PRIO(0)) dut_1 (
    .clk(clk), .reset(reset), .req_i(req_1), .release_i(rel_1),
    .gnt_o(g_1), .gnt_valid_o(v_1), .gnt_id_o(id_1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scan requesters in rotating order starting at the pointer.
  function automatic int pick(input int n, input logic [3:0] r, input int p);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = (p + k) % n;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_own[u] = -1;
      m_ptr[u] = 0;
    end
  endtask

  task automatic model_cycle(input int u, input logic [3:0] r, input logic rel);
    if (m_own[u] < 0) begin
      m_own[u] = pick(m_n[u], r, m_ptr[u]);
    end else if (rel || !r[m_own[u]]) begin
      if (!m_fix[u]) m_ptr[u] = (m_own[u] + 1) % m_n[u];
      m_own[u] = pick(m_n[u], r, m_ptr[u]);
    end
  endtask

  task automatic chk_unit(input string nm, input int u, input logic [3:0] g, input logic v, input logic [1:0] id);
    int eg, ev, ei;
    eg = (m_own[u] < 0) ? 0 : (1 << m_own[u]);
    ev = (m_own[u] < 0) ? 0 : 1;
    ei = (m_own[u] < 0) ? 0 : m_own[u];
    chk({nm, "_gnt"}, 32'(g), 32'(eg));
    chk({nm, "_valid"}, 32'(v), 32'(ev));
    chk({nm, "_id"}, 32'(id), 32'(ei));
  endtask

  task automatic check_all();
    chk_unit("rr", 0, g_rr, v_rr, id_rr);
    chk_unit("fx", 1, g_fx, v_fx, id_fx);
    chk_unit("n1", 2, {3'b000, g_1}, v_1, {1'b0, id_1});
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      model_cycle(0, req_rr, rel_rr);
      model_cycle(1, req_fx, rel_fx);
      model_cycle(2, {3'b000, req_1}, rel_1);
    end
    #1;
    check_all();
  endtask

  logic [3:0] seq1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset  = 1'b0;
    req_rr = 4'b1111; rel_rr = 1'b1;
    req_fx = 4'b1111; rel_fx = 1'b1;
    req_1  = 1'b1;    rel_1  = 1'b1;
    model_reset();

    // Reset held with requests pending: everything stays zero.
    step();
    step();
    chk("reset_gnt", 32'(g_rr), 32'd0);

    // Release every cycle: full rotation with no idle bubbles.
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_seq", 32'(g_rr), 32'(seq1[k]));
      chk("t1_fixed", 32'(g_fx), 32'b0001);
    end

    // Hold: owner 0 keeps the grant while other requests wait.
    req_rr = 4'b0101; rel_rr = 1'b0;
    rel_fx = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_hold", 32'(g_rr), 32'b0001);
    end
    rel_rr = 1'b1;
    step();
    chk("t2_after_rel", 32'(g_rr), 32'b0100);

    // Implicit release via request drop, wrapping from pointer 3.
    rel_rr = 1'b0;
    req_rr = 4'b0100;
    step();
    chk("t3_owner2", 32'(id_rr), 32'd2);
    req_rr = 4'b0001;
    req_fx = 4'b1100;
    step();
    chk("t3_wrap", 32'(g_rr), 32'b0001);
    chk("t4_fixed_1100", 32'(g_fx), 32'b0100);
    req_rr = 4'b0000;
    req_1  = 1'b0;
    step();
    chk("t3_idle_valid", 32'(v_rr), 32'd0);
    chk("t3_idle_id", 32'(id_rr), 32'd0);

    // Single requester is re-granted on every release.
    req_rr = 4'b0010;
    req_1  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rel_rr = k[0];
      step();
      chk("t5_single_gnt", 32'(g_rr), 32'b0010);
      chk("t5_single_id", 32'(id_rr), 32'd1);
    end

    // Asynchronous reset mid-transaction clears outputs before the next edge.
    rel_rr = 1'b0;
    req_rr = 4'b1000;
    step();
    chk("t6_busy", 32'(g_rr), 32'b1000);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6_async_gnt", 32'(g_rr), 32'd0);
    check_all();
    step();
    reset  = 1'b1;
    req_rr = 4'b1001;
    step();
    chk("t6_after_reset", 32'(g_rr), 32'b0001);

    // Randomized traffic against the model, with occasional asynchronous resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) req_rr = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req_fx = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req_1  = 1'($urandom);
      rel_rr = ($urandom_range(0, 3) == 0);
      rel_fx = ($urandom_range(0, 3) == 0);
      rel_1  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        reset = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
